// File: rtl/nano_mem_arbiter.sv
// Single-port memory arbiter for nano_rv32i: data side has priority over fetch,
// with a streak counter that forces a fetch grant after STARVE_MAX data grants.
module nano_mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        i_req_i,
   input  logic [31:0] i_addr_i,
   output logic        i_gnt_o,
   output logic        i_valid_o,
   output logic [31:0] i_data_o,
   input  logic        d_req_i,
   input  logic [31:0] d_addr_i,
   input  logic [3:0]  d_rd_i,
   input  logic [3:0]  d_we_i,
   input  logic [31:0] d_data_i,
   output logic        d_gnt_o,
   output logic        d_valid_o,
   output logic [31:0] d_data_o,
   output logic        m_req_o,
   output logic [31:0] m_addr_o,
   output logic [3:0]  m_rd_o,
   output logic [3:0]  m_we_o,
   output logic [31:0] m_wdata_o,
   input  logic        m_ack_i,
   input  logic [31:0] m_rdata_i
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE = 2'd0, I_BUSY = 2'd1, D_BUSY = 2'd2} state_t;

   state_t     state;
   logic [3:0] streak;
   logic       grant_d, grant_i;
   logic [3:0] d_rd_sel;

   // Write wins over read; a data request with no enables becomes a full-word read.
   always_comb begin
      d_rd_sel = 4'b0000;
      if (d_we_i == 4'b0000)
         d_rd_sel = (d_rd_i != 4'b0000) ? d_rd_i : 4'b1111;
   end

   assign grant_d = d_req_i && !(i_req_i && streak == SMAX);
   assign grant_i = i_req_i && !grant_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         streak    <= 4'd0;
         i_gnt_o   <= 1'b0;
         i_valid_o <= 1'b0;
         i_data_o  <= 32'h0;
         d_gnt_o   <= 1'b0;
         d_valid_o <= 1'b0;
         d_data_o  <= 32'h0;
         m_req_o   <= 1'b0;
         m_addr_o  <= 32'h0;
         m_rd_o    <= 4'b0000;
         m_we_o    <= 4'b0000;
         m_wdata_o <= 32'h0;
      end else begin
         i_gnt_o   <= 1'b0;
         d_gnt_o   <= 1'b0;
         i_valid_o <= 1'b0;
         d_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= D_BUSY;
                  d_gnt_o   <= 1'b1;
                  streak    <= (streak == SMAX) ? streak : streak + 4'd1;
                  m_req_o   <= 1'b1;
                  m_addr_o  <= d_addr_i;
                  m_wdata_o <= d_data_i;
                  m_we_o    <= d_we_i;
                  m_rd_o    <= d_rd_sel;
               end else if (grant_i) begin
                  state     <= I_BUSY;
                  i_gnt_o   <= 1'b1;
                  streak    <= 4'd0;
                  m_req_o   <= 1'b1;
                  m_addr_o  <= i_addr_i;
                  m_wdata_o <= 32'h0;
                  m_we_o    <= 4'b0000;
                  m_rd_o    <= 4'b1111;
               end
            end
            I_BUSY: begin
               if (m_ack_i) begin
                  state     <= IDLE;
                  m_req_o   <= 1'b0;
                  i_valid_o <= 1'b1;
                  i_data_o  <= m_rdata_i;
               end
            end
            D_BUSY: begin
               // Stores also latch m_rdata_i; the core ignores it.
               if (m_ack_i) begin
                  state     <= IDLE;
                  m_req_o   <= 1'b0;
                  d_valid_o <= 1'b1;
                  d_data_o  <= m_rdata_i;
               end
            end
            default: begin
               state   <= IDLE;
               m_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/nano_mem_arbiter.md
Name: nano_mem_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch side and its load/store side.
- Sits between the nano_rv32i core ports and a unified instruction/data RAM or bus bridge.
- Serialises transactions with a 3-state FSM. Data has priority over fetch, with an anti-starvation counter that forces a fetch grant after a bounded streak of data grants.
- Returns read data and completion pulses to the side that owns each transaction.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- i_req_i  in  1  fetch request; held with i_addr_i until i_gnt_o
- i_addr_i  in  32  fetch word address
- i_gnt_o  out  1  one-cycle pulse: fetch accepted
- i_valid_o  out  1  one-cycle pulse: i_data_o valid
- i_data_o  out  32  fetched instruction
- d_req_i  in  1  data request; held with its payload until d_gnt_o
- d_addr_i  in  32  data address
- d_rd_i  in  4  byte read enables
- d_we_i  in  4  byte write enables
- d_data_i  in  32  store data
- d_gnt_o  out  1  one-cycle pulse: data access accepted
- d_valid_o  out  1  one-cycle pulse: data access complete (loads and stores)
- d_data_o  out  32  load data
- m_req_o  out  1  memory request; held until m_ack_i
- m_addr_o  out  32  memory address
- m_rd_o  out  4  memory byte read enables
- m_we_o  out  4  memory byte write enables
- m_wdata_o  out  32  memory write data
- m_ack_i  in  1  memory completion; m_rdata_i valid in the same cycle
- m_rdata_i  in  32  memory read data

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE, streak counter 0.
  - All outputs 0, including every m_* output, both data buses, and all gnt/valid pulses.
  - Reset mid-transaction abandons the transaction: no valid pulse is issued, and m_req_o drops the next cycle.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE arbitration, evaluated each cycle:
  - If d_req_i && !(i_req_i && streak==STARVE_MAX), grant data. Next state D_BUSY; d_gnt_o=1 next cycle; streak increments, saturating at STARVE_MAX.
  - Else if i_req_i, grant fetch. Next state I_BUSY; i_gnt_o=1 next cycle; streak clears to 0.
  - Else stay in IDLE.
- Payload capture: the request payload is registered at the arbitration edge and held stable on the m_* outputs until ack.
- Fetch transaction (I_BUSY): m_addr_o=i_addr_i, m_rd_o=4'b1111, m_we_o=0, m_wdata_o=0.
- Data transaction (D_BUSY):
  - m_addr_o=d_addr_i, m_wdata_o=d_data_i.
  - If d_we_i!=0: m_we_o=d_we_i, m_rd_o=0. Write wins when both enables are non-zero.
  - Else if d_rd_i!=0: m_rd_o=d_rd_i, m_we_o=0.
  - Else (both zero): m_rd_o=4'b1111.
- BUSY states:
  - m_req_o=1 for the whole state.
  - On m_ack_i, go to IDLE. The owner's valid pulses for one cycle and its data register loads m_rdata_i. For stores, d_data_o loads m_rdata_i as well; the requester ignores it.
  - Without m_ack_i, stay in the state with no timeout.
- Cycle timing:
  - Request seen in IDLE at cycle N: gnt and m_req_o high in N+1.
  - With ack in N+1: valid in N+2 and m_req_o low in N+2; earliest next grant decision is N+2.
  - Zero-wait throughput is one transaction per 2 cycles.
- m_ack_i while in IDLE is ignored; it must not produce a valid pulse.
- i_data_o and d_data_o hold their last loaded value between valid pulses.
- A request may be asserted in the same cycle as the previous transaction's valid pulse.
- Requesters drop req after gnt. A req still high after gnt is treated as a new request.

Test Plan:
- Single fetch: i_req_i=1, addr 0x100; memory acks 1 cycle after m_req_o rises with rdata 0x00500093. Required: i_gnt_o at N+1; m_addr_o=0x100, m_rd_o=4'hF; i_valid_o at N+3 with i_data_o=0x00500093.
- Simultaneous requests: i_req_i and d_req_i in the same cycle, d_we_i=4'b0011, addr 0x204, data 0xAABBCCDD. Required: data granted first with m_we_o=4'h3, m_wdata_o=0xAABBCCDD; fetch granted in the next IDLE; d_valid_o precedes i_valid_o.
- Starvation: d_req_i held high continuously with i_req_i high and STARVE_MAX=4. Required: grant order D,D,D,D,I,D,D,D,D,I...
- Wait states: memory delays m_ack_i by 5 cycles. Required: m_req_o and m_addr_o stable for all 6 cycles; exactly one valid pulse.
- Reset during D_BUSY (before ack): required next cycle: m_req_o=0, no d_valid_o, streak 0. A subsequent stray m_ack_i produces no valid pulse.
- Both enables zero: data request with d_rd_i=0 and d_we_i=0. Required: m_rd_o=4'hF, m_we_o=0.
